// File: rtl/bus_io_port_if.sv
// rtl/bus_io_port_if.sv - cpu strobes and TX/RX stream signals of bus_io_port
interface bus_io_port_if #(
    parameter int WIDTH = 16
);
    logic             i_w;
    logic             i_s;
    logic             i_sel;
    logic [WIDTH-1:0] o_txData;
    logic             o_txValid;
    logic             i_txReady;
    logic [WIDTH-1:0] i_rxData;
    logic             i_rxValid;
    logic             o_rxReady;

    modport slave (
        input  i_w, i_s, i_sel, i_txReady, i_rxData, i_rxValid,
        output o_txData, o_txValid, o_rxReady
    );

    modport master (
        output i_w, i_s, i_sel, i_txReady, i_rxData, i_rxValid,
        input  o_txData, o_txValid, o_rxReady
    );
endinterface

// File: rtl/bus_io_port.sv
// rtl/bus_io_port.sv - cpu bus responder with TX/RX FIFOs and status/command port
// Optional sticky error flags: define BUS_IO_ERROR_FLAGS_EN.
module bus_io_port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    inout  wire  [WIDTH-1:0] bus,
    bus_io_port_if.slave     port
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] txMem [DEPTH];
    logic [WIDTH-1:0] rxMem [DEPTH];
    logic [AW-1:0]    txWr, txRd, rxWr, rxRd;
    logic [CW-1:0]    txCount, rxCount;
    logic             txOvf, rxUnf;

    logic txEmpty, txFull, rxEmpty, rxFull;
    logic dataRead, dataWrite, cmdWrite;
    logic txPush, txPop, rxPush, rxPop;
    logic flushTx, flushRx;
    logic [15:0]      status;
    logic [WIDTH-1:0] rxHead, busOut;

    assign txEmpty = (txCount == '0);
    assign txFull  = (txCount == FULL);
    assign rxEmpty = (rxCount == '0);
    assign rxFull  = (rxCount == FULL);

    // A show strobe always wins: i_w together with i_s is a read only.
    assign dataRead  = port.i_s & ~port.i_sel;
    assign dataWrite = port.i_w & ~port.i_s & ~port.i_sel;
    assign cmdWrite  = port.i_w & ~port.i_s & port.i_sel;

    assign flushTx = cmdWrite & bus[1];
    assign flushRx = cmdWrite & bus[2];

    assign txPop  = ~txEmpty & port.i_txReady;
    assign txPush = dataWrite & (~txFull | txPop);
    assign rxPop  = dataRead & ~rxEmpty;
    assign rxPush = port.i_rxValid & port.o_rxReady;

    assign port.o_txValid = ~txEmpty;
    assign port.o_txData  = txEmpty ? '0 : txMem[txRd];
    assign port.o_rxReady = ~i_reset & ~rxFull;

    assign rxHead = rxEmpty ? '0 : rxMem[rxRd];
    assign status = {4'(txCount), 4'(rxCount), 2'b00, rxUnf, txOvf,
                     txFull, txEmpty, rxFull, rxEmpty};
    assign busOut = port.i_sel ? WIDTH'(status) : rxHead;
    assign bus    = (port.i_s & ~i_reset) ? busOut : 'z;

    always_ff @(posedge i_clock) begin
        if (txPush) txMem[txWr] <= bus;
        if (rxPush) rxMem[rxWr] <= port.i_rxData;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            txWr    <= '0;
            txRd    <= '0;
            txCount <= '0;
            rxWr    <= '0;
            rxRd    <= '0;
            rxCount <= '0;
        end else begin
            if (flushTx) begin
                txWr    <= '0;
                txRd    <= '0;
                txCount <= '0;
            end else begin
                if (txPush) txWr <= txWr + 1'b1;
                if (txPop)  txRd <= txRd + 1'b1;
                txCount <= txCount + CW'(txPush) - CW'(txPop);
            end
            if (flushRx) begin
                rxWr    <= '0;
                rxRd    <= '0;
                rxCount <= '0;
            end else begin
                if (rxPush) rxWr <= rxWr + 1'b1;
                if (rxPop)  rxRd <= rxRd + 1'b1;
                rxCount <= rxCount + CW'(rxPush) - CW'(rxPop);
            end
        end
    end

`ifdef BUS_IO_ERROR_FLAGS_EN
    logic clearFlags;
    assign clearFlags = cmdWrite & bus[0];

    // A new error event in the same cycle as a clear command keeps the flag set.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            txOvf <= 1'b0;
            rxUnf <= 1'b0;
        end else begin
            txOvf <= (dataWrite & ~txPush) | (txOvf & ~clearFlags);
            rxUnf <= (dataRead & rxEmpty) | (rxUnf & ~clearFlags);
        end
    end
`else
    assign txOvf = 1'b0;
    assign rxUnf = 1'b0;
`endif
endmodule

// File: tb/tb_bus_io_port.sv
// tb/tb_bus_io_port.sv - randomized and directed bench for bus_io_port against a queue model
module tb_bus_io_port;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
`ifdef BUS_IO_ERROR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic i_clock = 1'b0;
    logic i_reset;
    wire  [WIDTH-1:0] bus;
    logic tbDrive;
    logic [WIDTH-1:0] tbVal;

    assign bus = tbDrive ? tbVal : 'z;
    always #5 i_clock = ~i_clock;

    bus_io_port_if #(.WIDTH(WIDTH)) port ();

    bus_io_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus),
        .port    (port)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] txQ[$];
    logic [15:0] rxQ[$];
    bit mOvf, mUnf;

    bit curRst, curW, curS, curSel, curTxReady, curRxValid;
    logic [15:0] curWdata, curRxData;

    function automatic logic [15:0] expStatus();
        int v;
        v = (txQ.size() << 12) | (rxQ.size() << 8) | (int'(mUnf) << 5) | (int'(mOvf) << 4)
          | (int'(txQ.size() == DEPTH) << 3) | (int'(txQ.size() == 0) << 2)
          | (int'(rxQ.size() == DEPTH) << 1) | int'(rxQ.size() == 0);
        return 16'(v);
    endfunction

    function automatic logic [15:0] expRead(bit sel);
        if (sel) return expStatus();
        return (rxQ.size() != 0) ? rxQ[0] : 16'h0000;
    endfunction

    function automatic logic [15:0] expTxData();
        return (txQ.size() != 0) ? txQ[0] : 16'h0000;
    endfunction

    task automatic setIn(input bit rst, input bit w, input bit s, input bit sel,
                         input logic [15:0] wdata, input bit txReady,
                         input bit rxValid, input logic [15:0] rxData);
        curRst = rst; curW = w; curS = s; curSel = sel; curWdata = wdata;
        curTxReady = txReady; curRxValid = rxValid; curRxData = rxData;
        i_reset        = rst;
        port.i_w       = w;
        port.i_s       = s;
        port.i_sel     = sel;
        port.i_txReady = txReady;
        port.i_rxValid = rxValid;
        port.i_rxData  = rxData;
        tbDrive        = w & ~s;
        tbVal          = wdata;
        #1;
    endtask

    // Advance one clock and apply the FIFO rules to the queue model.
    task automatic step();
        bit dataRead, dataWrite, cmdWrite, clr, drop, unf, rxReadyPre, txPop;
        @(posedge i_clock);
        if (curRst) begin
            txQ.delete(); rxQ.delete(); mOvf = 0; mUnf = 0;
        end else begin
            dataRead   = curS && !curSel;
            dataWrite  = curW && !curS && !curSel;
            cmdWrite   = curW && !curS && curSel;
            clr        = cmdWrite && curWdata[0];
            drop       = 0;
            unf        = 0;
            rxReadyPre = rxQ.size() < DEPTH;
            txPop      = (txQ.size() > 0) && curTxReady;
            if (cmdWrite && curWdata[1]) txQ.delete();
            else begin
                if (txPop) void'(txQ.pop_front());
                if (dataWrite) begin
                    if (txQ.size() < DEPTH) txQ.push_back(curWdata);
                    else drop = 1;
                end
            end
            if (cmdWrite && curWdata[2]) rxQ.delete();
            else begin
                if (dataRead) begin
                    if (rxQ.size() > 0) void'(rxQ.pop_front());
                    else unf = 1;
                end
                if (curRxValid && rxReadyPre) rxQ.push_back(curRxData);
            end
            if (FLAGS) begin
                mOvf = drop || (mOvf && !clr);
                mUnf = unf || (mUnf && !clr);
            end
        end
        #1;
    endtask

    task automatic idleStep();
        setIn(0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        step();
    endtask

    task automatic test_reset();
        setIn(1, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        checks++;
        if (port.o_rxReady !== 1'b0) begin
            errors++; $display("FAIL reset_rxReady: got %b expected 0", port.o_rxReady);
        end
        step(); step();
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus !== 16'h0005 || bus !== expStatus()) begin
            errors++; $display("FAIL reset_status: got %h expected 0005", bus);
        end
        checks++;
        if (port.o_txValid !== 1'b0 || port.o_txData !== 16'h0) begin
            errors++; $display("FAIL reset_tx: got valid=%b data=%h expected 0/0000",
                               port.o_txValid, port.o_txData);
        end
        checks++;
        if (port.o_rxReady !== 1'b1) begin
            errors++; $display("FAIL reset_rxReady_after: got %b expected 1", port.o_rxReady);
        end
        step();
    endtask

    task automatic test_tx_fill_drain();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 16'(16'h1111 * (i + 1));
            setIn(0, 1, 0, 0, w, 0, 0, 16'h0);
            step();
        end
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus !== expStatus()) begin
            errors++; $display("FAIL tx_full_status: got %h expected %h", bus, expStatus());
        end
        step();
        for (int i = 0; i < 4; i++) begin
            w = 16'(16'h1111 * (i + 1));
            setIn(0, 0, 0, 0, 16'h0, 1, 0, 16'h0);
            checks++;
            if (port.o_txValid !== 1'b1 || port.o_txData !== w || w !== expTxData()) begin
                errors++; $display("FAIL tx_drain_%0d: got valid=%b data=%h expected 1/%h",
                                   i, port.o_txValid, port.o_txData, w);
            end
            step();
        end
        setIn(0, 0, 0, 0, 16'h0, 1, 0, 16'h0);
        checks++;
        if (port.o_txValid !== 1'b0) begin
            errors++; $display("FAIL tx_drained_valid: got %b expected 0", port.o_txValid);
        end
        step();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            setIn(0, 1, 0, 0, 16'(i + 1), 0, 0, 16'h0);
            step();
        end
        setIn(0, 1, 0, 0, 16'hDEAD, 0, 0, 16'h0);
        step();
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus[4] !== FLAGS || bus !== expStatus()) begin
            errors++; $display("FAIL ovf_status: got %h expected %h", bus, expStatus());
        end
        step();
        setIn(0, 1, 0, 1, 16'h0001, 0, 0, 16'h0);
        step();
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus[4] !== 1'b0 || bus !== expStatus()) begin
            errors++; $display("FAIL ovf_cleared: got %h expected %h", bus, expStatus());
        end
        step();
        setIn(0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        checks++;
        if (port.o_txData !== 16'h0001) begin
            errors++; $display("FAIL ovf_head_kept: got %h expected 0001", port.o_txData);
        end
        step();
        setIn(0, 1, 0, 1, 16'h0002, 0, 0, 16'h0);
        step();
        setIn(0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        checks++;
        if (port.o_txValid !== 1'b0) begin
            errors++; $display("FAIL tx_flush_valid: got %b expected 0", port.o_txValid);
        end
        step();
    endtask

    task automatic test_rx_read();
        setIn(0, 0, 0, 0, 16'h0, 0, 1, 16'hBEEF);
        step();
        setIn(0, 0, 1, 0, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus !== 16'hBEEF) begin
            errors++; $display("FAIL rx_read_data: got %h expected beef", bus);
        end
        step();
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus[11:8] !== 4'h0 || bus !== expStatus()) begin
            errors++; $display("FAIL rx_read_count: got %h expected %h", bus, expStatus());
        end
        step();
        setIn(0, 0, 1, 0, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus !== 16'h0000) begin
            errors++; $display("FAIL rx_empty_read: got %h expected 0000", bus);
        end
        step();
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus[5] !== FLAGS || bus !== expStatus()) begin
            errors++; $display("FAIL rx_unf_status: got %h expected %h", bus, expStatus());
        end
        step();
        setIn(0, 1, 0, 1, 16'h0001, 0, 0, 16'h0);
        step();
    endtask

    task automatic test_full_push_pop();
        logic [15:0] order [4];
        order[0] = 16'h2222; order[1] = 16'h3333; order[2] = 16'h4444; order[3] = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            setIn(0, 1, 0, 0, 16'(16'h1111 * (i + 1)), 0, 0, 16'h0);
            step();
        end
        setIn(0, 1, 0, 0, 16'h5555, 1, 0, 16'h0);
        checks++;
        if (port.o_txData !== 16'h1111) begin
            errors++; $display("FAIL fullpp_head: got %h expected 1111", port.o_txData);
        end
        step();
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus[15:12] !== 4'd4 || bus !== expStatus()) begin
            errors++; $display("FAIL fullpp_count: got %h expected %h", bus, expStatus());
        end
        step();
        for (int i = 0; i < 4; i++) begin
            setIn(0, 0, 0, 0, 16'h0, 1, 0, 16'h0);
            checks++;
            if (port.o_txData !== order[i] || order[i] !== expTxData()) begin
                errors++; $display("FAIL fullpp_order_%0d: got %h expected %h",
                                   i, port.o_txData, order[i]);
            end
            step();
        end
    endtask

    task automatic test_rx_empty_push_read();
        setIn(0, 0, 1, 0, 16'h0, 0, 1, 16'h7777);
        checks++;
        if (bus !== 16'h0000) begin
            errors++; $display("FAIL rx_pushread_bus: got %h expected 0000", bus);
        end
        step();
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus[11:8] !== 4'd1 || bus !== expStatus()) begin
            errors++; $display("FAIL rx_pushread_count: got %h expected %h", bus, expStatus());
        end
        step();
        setIn(0, 0, 1, 0, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus !== 16'h7777) begin
            errors++; $display("FAIL rx_pushread_word: got %h expected 7777", bus);
        end
        step();
        setIn(0, 1, 0, 1, 16'h0001, 0, 0, 16'h0);
        step();
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++) begin
            setIn(0, 0, 0, 0, 16'h0, 0, 1, 16'(16'hA000 + i));
            step();
        end
        setIn(0, 1, 0, 1, 16'h0004, 0, 0, 16'h0);
        step();
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (bus[11:8] !== 4'd0 || port.o_rxReady !== 1'b1 || bus !== expStatus()) begin
            errors++; $display("FAIL rx_flush: got status=%h ready=%b expected %h/1",
                               bus, port.o_rxReady, expStatus());
        end
        step();
        setIn(0, 1, 0, 0, 16'h1234, 0, 0, 16'h0);
        step();
        setIn(1, 0, 0, 0, 16'h0, 1, 1, 16'h4321);
        step();
        setIn(0, 0, 1, 1, 16'h0, 0, 0, 16'h0);
        checks++;
        if (port.o_txValid !== 1'b0 || bus !== 16'h0005) begin
            errors++; $display("FAIL reset_midflight: got valid=%b status=%h expected 0/0005",
                               port.o_txValid, bus);
        end
        step();
    endtask

    task automatic test_random();
        bit w, s, sel;
        logic [15:0] wd;
        for (int n = 0; n < 400; n++) begin
            w   = ($urandom_range(0, 2) == 0);
            s   = ($urandom_range(0, 2) == 0);
            sel = ($urandom_range(0, 5) == 0);
            wd  = sel ? 16'($urandom_range(0, 7)) : 16'($urandom);
            setIn(0, w, s, sel, wd, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 16'($urandom));
            checks++;
            if (port.o_txValid !== (txQ.size() != 0) || port.o_txData !== expTxData()) begin
                errors++; $display("FAIL rand_tx_%0d: got valid=%b data=%h expected %b/%h",
                                   n, port.o_txValid, port.o_txData, txQ.size() != 0, expTxData());
            end
            checks++;
            if (port.o_rxReady !== (rxQ.size() < DEPTH)) begin
                errors++; $display("FAIL rand_rxReady_%0d: got %b expected %b",
                                   n, port.o_rxReady, rxQ.size() < DEPTH);
            end
            if (s) begin
                checks++;
                if (bus !== expRead(sel)) begin
                    errors++; $display("FAIL rand_bus_%0d: got %h expected %h", n, bus, expRead(sel));
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_tx_fill_drain();
        test_overflow();
        test_rx_read();
        test_full_push_pop();
        test_rx_empty_push_read();
        test_flush_reset();
        test_random();
        idleStep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
